// File: rtl/alu_issue_queue_pkg.sv
// ============================================================================
// Module   : alu_issue_queue_pkg
// Brief    : Shared opcode, instruction and result types for the ALU issue path
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_queue_pkg;

   localparam int ALU_LATENCY_DEFAULT = 1;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      MUL = 3'd2,
      AND = 3'd3,
      OR  = 3'd4,
      XOR = 3'd5,
      SLL = 3'd6,
      SRL = 3'd7
   } opcode_t;

   typedef struct packed {
      opcode_t     opcode;
      logic [31:0] a;
      logic [31:0] b;
   } instruction_t;

   typedef struct packed {
      opcode_t     opcode;
      logic [31:0] data;
   } result_t;

endpackage

`default_nettype wire

// File: rtl/alu_sync_fifo.sv
// ============================================================================
// Module   : alu_sync_fifo
// Brief    : Synchronous instruction FIFO with separate occupancy counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sync_fifo
   import alu_issue_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  instruction_t             wdata,
   input  logic                     pop,
   output instruction_t             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int                  c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]    c_FULL  = (c_PTR_W + 1)'(DEPTH);

   instruction_t          r_mem [DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_PTR_W:0]      r_count;
   logic                  w_push;
   logic                  w_pop;

   // Guard locally so the FIFO stays consistent even if a caller misbehaves.
   assign w_push = push && (r_count != c_FULL);
   assign w_pop  = pop  && (r_count != '0);

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign rdata = r_mem[r_rd_ptr];
   assign count = r_count;
   assign full  = (r_count == c_FULL);
   assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/alu_issue_queue.sv
// ============================================================================
// Module   : alu_issue_queue
// Brief    : Buffers instructions, issues them onto IW, re-times ALU results
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_queue
   import alu_issue_queue_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int ALU_LATENCY = ALU_LATENCY_DEFAULT
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  instruction_t             in_inst,
   input  logic                     issue_en,
   output instruction_t             IW,
   output logic                     issue_valid,
   input  logic [31:0]              alu_result,
   output logic                     res_valid,
   output opcode_t                  res_opcode,
   output logic [31:0]              res_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   instruction_t              w_head;
   logic                      w_push;
   logic                      w_pop;
   instruction_t              r_iw;
   logic                      r_issue_valid;
   logic [ALU_LATENCY-1:0]    r_pipe_valid;
   opcode_t                   r_pipe_op [ALU_LATENCY];
   result_t                   r_res;
   logic                      r_res_valid;

   assign in_ready = !full && !reset;
   assign w_push   = in_valid && in_ready;
   assign w_pop    = !empty && issue_en;

   alu_sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push),
      .wdata (in_inst),
      .pop   (w_pop),
      .rdata (w_head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_iw          <= '0;
         r_issue_valid <= 1'b0;
      end else if (w_pop) begin
         r_iw          <= w_head;
         r_issue_valid <= 1'b1;
      end else begin
         r_issue_valid <= 1'b0;
      end
   end

   // Tag pipe mirrors the ALU's internal latency so the tail lines up with alu_result.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pipe_valid[0] <= 1'b0;
         r_pipe_op[0]    <= ADD;
      end else begin
         r_pipe_valid[0] <= r_issue_valid;
         r_pipe_op[0]    <= r_iw.opcode;
      end
   end

   for (genvar gi = 1; gi < ALU_LATENCY; gi++) begin : g_pipe_stage
      always_ff @(posedge clock) begin
         if (reset) begin
            r_pipe_valid[gi] <= 1'b0;
            r_pipe_op[gi]    <= ADD;
         end else begin
            r_pipe_valid[gi] <= r_pipe_valid[gi-1];
            r_pipe_op[gi]    <= r_pipe_op[gi-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_res       <= '0;
         r_res_valid <= 1'b0;
      end else if (r_pipe_valid[ALU_LATENCY-1]) begin
         r_res.opcode <= r_pipe_op[ALU_LATENCY-1];
         r_res.data   <= alu_result;
         r_res_valid  <= 1'b1;
      end else begin
         r_res_valid  <= 1'b0;
      end
   end

   assign IW          = r_iw;
   assign issue_valid = r_issue_valid;
   assign res_valid   = r_res_valid;
   assign res_opcode  = r_res.opcode;
   assign res_data    = r_res.data;

endmodule

`default_nettype wire

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Upstream feeder for the ALU; the ALU receives its instruction word on its IW port.
- Accepts instruction_t words over a valid/ready handshake and buffers them in a FIFO.
- Issues one instruction per cycle onto IW when issue is enabled.
- Re-times the ALU result into a tagged, latency-matched result stream: res_valid plus opcode.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- ALU_LATENCY, 1, cycles from IW valid to ALU result valid; 1 means the ALU registers its result on clock.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  producer has an instruction.
- in_ready  output  1  block can accept an instruction.
- in_inst  input  instruction_t  instruction {opcode, a[31:0], b[31:0]}.
- issue_en  input  1  stall control; 0 blocks popping.
- IW  output  instruction_t  instruction to the ALU; registered.
- issue_valid  output  1  IW carries a newly issued instruction this cycle.
- alu_result  input  32  ALU result.
- res_valid  output  1  res_data/res_opcode valid; one-cycle pulse per instruction.
- res_opcode  output  opcode_t  opcode of the completed instruction.
- res_data  output  32  captured ALU result.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values after a reset edge:
  - IW = '0 (opcode ADD, a = b = 0); issue_valid = 0.
  - res_valid = 0, res_data = 0, res_opcode = ADD.
  - count = 0, empty = 1, full = 0.
- in_ready = !full && !reset; it is combinational.
- Push: in_valid && in_ready at a rising edge writes in_inst to the FIFO tail.
- Pop: !empty && issue_en at a rising edge. IW <= head, issue_valid <= 1; otherwise issue_valid <= 0 and IW holds its last value.
- No bypass. An instruction accepted at edge k appears on IW no earlier than after edge k+1.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged.
- When full, no push occurs, even if a pop happens the same edge; in_ready is already 0.
- When empty, no pop occurs and issue_valid = 0 regardless of issue_enable.
- Pointers are log2(DEPTH)-bit and wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- Result pipe:
  - A shift register of ALU_LATENCY stages carries {issue_valid, IW.opcode}.
  - When the tail stage is valid at an edge: res_valid <= 1, res_data <= alu_result, res_opcode <= tail opcode.
  - Otherwise res_valid <= 0 and res_data/res_opcode hold.
  - Issue-to-result latency is ALU_LATENCY+1 cycles. For ALU_LATENCY=1, issue in cycle c gives res_valid in cycle c+2.
- Results are never back-pressured. Back-to-back issues give back-to-back res_valid in order.
- Reset mid-operation flushes the FIFO and clears the result pipe. In-flight results are dropped and never produce res_valid.
- Arithmetic: there is none on data. res_data is exactly the 32-bit alu_result with no extension.

Decomposition:
- Shared package definitions holds:
  - opcode_t enum (ADD, SUB, MUL, ...).
  - instruction_t packed struct {opcode_t opcode; logic [31:0] a, b;}.
  - localparam ALU_LATENCY_DEFAULT = 1.
  - result_t struct {opcode_t opcode; logic [31:0] data;}.
- Sub-module alu_sync_fifo: generic instruction_t FIFO with push, pop, count, full, empty.
- The top level adds the issue register and the latency pipe.

Test Plan:
- Reset then idle -> in_ready=1, empty=1, count=0, issue_valid=0, res_valid=0, IW.a=0.
- Push {ADD,10,15} with issue_en=1 and a registered reference ALU:
  - issue_valid pulses 2 cycles after acceptance with IW.a=10, IW.b=15.
  - res_valid pulses 2 cycles later with res_data=25, res_opcode=ADD.
- Fill with issue_en=0: push 4 words {SUB,20,5}x4 -> count=4, full=1, in_ready=0; a 5th in_valid is not accepted. Raise issue_en -> 4 consecutive res_valid, each with res_data=15.
- Simultaneous push and pop at count=2 -> count stays 2. Issue order matches push order across pointer wrap, checked over 10 pushes of a=i, b=1 for ADD, giving results 1..10 in order.
- Assert reset one cycle after issuing {ADD,1,2} -> no res_valid for it, count=0, and res_data returns to 0.
- issue_en toggling 1,0,1 with 3 queued words -> issue_valid pattern 1,0,1 and res_valid follows the same pattern delayed by ALU_LATENCY+1.
